// File: rtl/l2_tag_controller_if.sv
// L1 request / bus snoop / response channels of the L2 tag controller.
// master = L1 + bus side, slave = tag controller.
interface l2_tag_controller_if #(
  parameter int ADDR_W = 24,
  parameter int WAY_W  = 3
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic              snoop_valid;
  logic              snoop_ready;
  logic [1:0]        snoop_op;
  logic [ADDR_W-1:0] snoop_addr;
  logic              rsp_valid;
  logic              rsp_hit;
  logic [WAY_W-1:0]  rsp_way;
  logic [1:0]        rsp_mesi;
  logic              evict_valid;
  logic [ADDR_W-1:0] evict_addr;
  logic              snoop_rsp_valid;
  logic [1:0]        snoop_result;

  modport master (
    output req_valid, req_op, req_addr, snoop_valid, snoop_op, snoop_addr,
    input  req_ready, snoop_ready, rsp_valid, rsp_hit, rsp_way, rsp_mesi,
           evict_valid, evict_addr, snoop_rsp_valid, snoop_result
  );

  modport slave (
    input  req_valid, req_op, req_addr, snoop_valid, snoop_op, snoop_addr,
    output req_ready, snoop_ready, rsp_valid, rsp_hit, rsp_way, rsp_mesi,
           evict_valid, evict_addr, snoop_rsp_valid, snoop_result
  );
endinterface

// File: rtl/l2_tag_controller.sv
// Set-associative L2 tag/MESI/LRU controller. Requests take IDLE->LOOKUP->UPDATE,
// snoops take IDLE->SNOOP; no line data is stored.
module l2_tag_controller #(
  parameter int WAYS       = 8,
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 12,
  parameter int BYTE_SEL   = 6,
  parameter int ADDR_W     = TAG_BITS + INDEX_BITS + BYTE_SEL,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  l2_tag_controller_if.slave bus,
  output logic [CNT_W-1:0] read_cnt,
  output logic [CNT_W-1:0] write_cnt,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);
  localparam int SETS  = 2 ** INDEX_BITS;
  localparam int WAY_W = $clog2(WAYS);

  localparam logic [1:0] MESI_I = 2'b00, MESI_S = 2'b01, MESI_E = 2'b10, MESI_M = 2'b11;
  localparam logic [1:0] OP_WR = 2'b01, OP_IF = 2'b10, SNP_RD = 2'b00;
  localparam logic [1:0] NOHIT = 2'b00, HIT = 2'b01, HITM = 2'b10;

  typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE, SNOOP} state_t;

  state_t state, nxt;

  logic [SETS-1:0][WAYS-1:0][TAG_BITS-1:0] tag_arr;
  logic [SETS-1:0][WAYS-1:0][1:0]          mesi_arr;
  logic [SETS-1:0][WAYS-1:0][WAY_W-1:0]    lru_arr;

  logic [1:0]            cap_op;
  logic [TAG_BITS-1:0]   cap_tag;
  logic [INDEX_BITS-1:0] cap_idx;
  logic                  lk_hit;
  logic [WAY_W-1:0]      lk_way;

  logic [WAYS-1:0]  match, free, oldest;
  logic             hit;
  logic [WAY_W-1:0] hit_way, free_way, old_way;
  logic [1:0]       sel_mesi, upd_mesi, snp_mesi;
  logic [WAY_W-1:0] sel_rank;

  logic              rsp_valid_q, rsp_hit_q, evict_valid_q, snp_valid_q;
  logic [WAY_W-1:0]  rsp_way_q;
  logic [1:0]        rsp_mesi_q, snp_res_q;
  logic [ADDR_W-1:0] evict_addr_q;

  logic req_take, snoop_take;

  assign bus.snoop_ready     = (state == IDLE);
  assign bus.req_ready       = (state == IDLE) && !bus.snoop_valid;
  assign snoop_take          = bus.snoop_valid && bus.snoop_ready;
  assign req_take            = bus.req_valid && bus.req_ready;
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_hit         = rsp_hit_q;
  assign bus.rsp_way         = rsp_way_q;
  assign bus.rsp_mesi        = rsp_mesi_q;
  assign bus.evict_valid     = evict_valid_q;
  assign bus.evict_addr      = evict_addr_q;
  assign bus.snoop_rsp_valid = snp_valid_q;
  assign bus.snoop_result    = snp_res_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Per-way tag match, free and LRU-oldest flags for the captured set
  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign match[w]  = (mesi_arr[cap_idx][w] != MESI_I) && (tag_arr[cap_idx][w] == cap_tag);
    assign free[w]   = (mesi_arr[cap_idx][w] == MESI_I);
    assign oldest[w] = (lru_arr[cap_idx][w] == WAY_W'(WAYS - 1));
  end

  // Lowest-index priority encode of hit / free / oldest ways
  always_comb begin
    hit      = |match;
    hit_way  = '0;
    free_way = '0;
    old_way  = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (match[w])  hit_way  = WAY_W'(w);
      if (free[w])   free_way = WAY_W'(w);
      if (oldest[w]) old_way  = WAY_W'(w);
    end
  end

  // Resulting line state for the selected way in UPDATE and the snooped way
  always_comb begin
    sel_mesi = mesi_arr[cap_idx][lk_way];
    sel_rank = lru_arr[cap_idx][lk_way];
    snp_mesi = mesi_arr[cap_idx][hit_way];
    if (lk_hit)                upd_mesi = (cap_op == OP_WR) ? MESI_M : sel_mesi;
    else if (cap_op == OP_WR)  upd_mesi = MESI_M;
    else if (cap_op == OP_IF)  upd_mesi = MESI_S;
    else                       upd_mesi = MESI_E;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Next state; snoops win over requests in IDLE
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (snoop_take) nxt = SNOOP; else if (req_take) nxt = LOOKUP;
      LOOKUP:  nxt = UPDATE;
      UPDATE:  nxt = IDLE;
      SNOOP:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Capture, lookup result, array writes, response strobes and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) begin
          tag_arr[s][w]  <= '0;
          mesi_arr[s][w] <= MESI_I;
          lru_arr[s][w]  <= WAY_W'(w);
        end
      cap_op        <= '0;
      cap_tag       <= '0;
      cap_idx       <= '0;
      lk_hit        <= 1'b0;
      lk_way        <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_hit_q     <= 1'b0;
      rsp_way_q     <= '0;
      rsp_mesi_q    <= MESI_I;
      evict_valid_q <= 1'b0;
      evict_addr_q  <= '0;
      snp_valid_q   <= 1'b0;
      snp_res_q     <= NOHIT;
      read_cnt      <= '0;
      write_cnt     <= '0;
      hit_cnt       <= '0;
      miss_cnt      <= '0;
    end else begin
      rsp_valid_q   <= 1'b0;
      evict_valid_q <= 1'b0;
      snp_valid_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (snoop_take) begin
            cap_op  <= bus.snoop_op;
            cap_tag <= bus.snoop_addr[ADDR_W-1 -: TAG_BITS];
            cap_idx <= bus.snoop_addr[BYTE_SEL +: INDEX_BITS];
          end else if (req_take) begin
            cap_op  <= bus.req_op;
            cap_tag <= bus.req_addr[ADDR_W-1 -: TAG_BITS];
            cap_idx <= bus.req_addr[BYTE_SEL +: INDEX_BITS];
            if (bus.req_op == OP_WR) write_cnt <= sat_inc(write_cnt);
            else                     read_cnt  <= sat_inc(read_cnt);
          end
        end
        LOOKUP: begin
          lk_hit <= hit;
          lk_way <= hit ? hit_way : ((|free) ? free_way : old_way);
        end
        UPDATE: begin
          // Ways younger than the selected one age by one; selected becomes MRU
          for (int w = 0; w < WAYS; w++)
            if (lru_arr[cap_idx][w] < sel_rank)
              lru_arr[cap_idx][w] <= lru_arr[cap_idx][w] + WAY_W'(1);
          lru_arr[cap_idx][lk_way]  <= '0;
          mesi_arr[cap_idx][lk_way] <= upd_mesi;
          if (!lk_hit) tag_arr[cap_idx][lk_way] <= cap_tag;
          rsp_valid_q <= 1'b1;
          rsp_hit_q   <= lk_hit;
          rsp_way_q   <= lk_way;
          rsp_mesi_q  <= upd_mesi;
          if (!lk_hit && sel_mesi == MESI_M) begin
            evict_valid_q <= 1'b1;
            evict_addr_q  <= {tag_arr[cap_idx][lk_way], cap_idx, {BYTE_SEL{1'b0}}};
          end
          if (lk_hit) hit_cnt  <= sat_inc(hit_cnt);
          else        miss_cnt <= sat_inc(miss_cnt);
        end
        SNOOP: begin
          snp_valid_q <= 1'b1;
          if (hit) begin
            snp_res_q <= (snp_mesi == MESI_M) ? HITM : HIT;
            mesi_arr[cap_idx][hit_way] <= (cap_op == SNP_RD) ? MESI_S : MESI_I;
          end else begin
            snp_res_q <= NOHIT;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
